// File: rtl/data_mem_responder_if.sv
// Data-port bus between the single-cycle core, the data memory responder
// and the downstream byte consumer of the MMIO output FIFO.
interface data_mem_responder_if;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;

  // Core + consumer side: drives requests, receives load data and FIFO head.
  modport master (
    output MemWrite, Addr, WriteData, out_ready,
    input  ReadData, out_valid, out_data
  );

  // Responder side.
  modport slave (
    input  MemWrite, Addr, WriteData, out_ready,
    output ReadData, out_valid, out_data
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data memory responder for the single-cycle core: word-addressed RAM plus a
// small MMIO window (TX byte FIFO, status, free-running cycle counter).
// Loads are combinational; stores and MMIO side effects land on the edge.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  data_mem_responder_if.slave   bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [7:0]    OFF_TXDATA = 8'h00;
  localparam logic [7:0]    OFF_STATUS = 8'h04;
  localparam logic [7:0]    OFF_CYCLES = 8'h08;
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_FULL   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};

  // Storage (not reset)
  logic [31:0] ram_q      [DEPTH_WORDS];
  logic [7:0]  fifo_mem_q [FIFO_DEPTH];

  // Control state
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          ovf_q,    ovf_d;
  logic [31:0]   cycles_q, cycles_d;

  // Decode
  logic          mmio_sel_s;
  logic [7:0]    off_s;
  logic [AW-1:0] ram_idx_s;
  logic          wr_en_s;
  logic          ram_we_s;
  logic          push_req_s;
  logic          stat_we_s;
  logic          cyc_we_s;
  logic          full_s;
  logic          empty_s;
  logic          pop_s;
  logic          push_s;
  logic          ovf_set_s;
  logic [31:0]   status_s;
  logic [31:0]   rdata_s;
  logic          unused_s;

  // Byte-lane bits are ignored: every access is a whole word.
  assign mmio_sel_s = (bus.Addr[31:16] == 16'hFFFF);
  assign off_s      = {bus.Addr[7:2], 2'b00};
  assign ram_idx_s  = bus.Addr[AW+1:2];
  assign unused_s   = ^{bus.Addr[15:8], bus.Addr[1:0]};

  // Writes are gated by reset so nothing lands while reset is held.
  assign wr_en_s    = bus.MemWrite & reset;
  assign ram_we_s   = wr_en_s & ~mmio_sel_s;
  assign push_req_s = wr_en_s & mmio_sel_s & (off_s == OFF_TXDATA);
  assign stat_we_s  = wr_en_s & mmio_sel_s & (off_s == OFF_STATUS);
  assign cyc_we_s   = wr_en_s & mmio_sel_s & (off_s == OFF_CYCLES);

  assign full_s    = (count_q == CNT_FULL);
  assign empty_s   = (count_q == CNT_ZERO);
  assign pop_s     = ~empty_s & bus.out_ready;
  // A push into a full FIFO still succeeds when the head leaves this cycle.
  assign push_s    = push_req_s & (~full_s | pop_s);
  assign ovf_set_s = push_req_s & full_s & ~pop_s;

  assign status_s = {29'd0, ovf_q, full_s, empty_s} | (32'(count_q) << 3'd3);

  assign bus.out_valid = ~empty_s;
  assign bus.out_data  = fifo_mem_q[rd_ptr_q];
  assign bus.ReadData  = rdata_s;

  // Combinational load mux: RAM word or MMIO register (old RAM data on write).
  always_comb begin
    rdata_s = 32'd0;
    if (mmio_sel_s) begin
      case (off_s)
        OFF_STATUS: rdata_s = status_s;
        OFF_CYCLES: rdata_s = cycles_q;
        default:    rdata_s = 32'd0;
      endcase
    end else begin
      rdata_s = ram_q[ram_idx_s];
    end
  end

  // Next-state for FIFO pointers/occupancy, overflow flag and cycle counter.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    cycles_d = cycles_q + 32'd1;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // A new overflow wins over a clear in the same cycle.
    if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else if (stat_we_s && bus.WriteData[2]) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    if (cyc_we_s) begin
      cycles_d = bus.WriteData;
    end else begin
      cycles_d = cycles_q + 32'd1;
    end
  end

  // Control registers; async reset empties the FIFO and clears the counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= CNT_ZERO;
      ovf_q    <= 1'b0;
      cycles_q <= 32'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      cycles_q <= cycles_d;
    end
  end

  // RAM word write; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      ram_q[ram_idx_s] <= bus.WriteData;
    end
  end

  // FIFO storage write at the tail slot.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_q[wr_ptr_q] <= bus.WriteData[7:0];
    end
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder for the single-cycle core's data port: consumes MemWrite/address/WriteData and returns ReadData combinationally in the same cycle.
- Contains a word-addressed RAM and a small memory-mapped I/O (MMIO) window.
- The MMIO window holds a byte output FIFO, drained by a downstream consumer over a valid/ready handshake, and a free-running cycle counter.
- Sits beside the core at the top level, wired to the core's data-memory signals.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit RAM words; power of two.
- FIFO_DEPTH, 4, output FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- MemWrite  input  1  write strobe from core
- Addr  input  32  byte address (core ALUResult)
- WriteData  input  32  store data from core
- ReadData  output  32  load data to core, combinational
- out_valid  output  1  FIFO head valid
- out_data  output  8  FIFO head byte
- out_ready  input  1  downstream accepts head

Behaviour:
- Address decode:
  - Addr[31:16] == 16'hFFFF selects MMIO, with offset Addr[7:0]; all other addresses select RAM.
  - RAM index is Addr[log2(DEPTH_WORDS)+1:2]. Higher bits are ignored, so accesses alias modulo DEPTH_WORDS.
  - Addr[1:0] is ignored everywhere; all accesses are whole words.
- RAM:
  - Write occurs on the rising edge when MemWrite=1.
  - Read is combinational from the current index. A read of the address being written in the same cycle returns the old contents.
  - RAM contents are not reset.
- MMIO map (other offsets read 0; writes to them are ignored):
  - 0x00 TXDATA. A write pushes WriteData[7:0] into the FIFO. If the FIFO is full and no pop happens that cycle, the byte is dropped and the sticky overflow flag is set. Reads return 0.
  - 0x04 STATUS. Read returns {25'b0, count[$clog2(FIFO_DEPTH):0] zero-extended into bits[6:3], overflow at bit2, full at bit1, empty at bit0}; count width is at most 4 bits for the default. A write with WriteData[2]=1 clears overflow. If a clear and a new overflow happen in the same cycle, the flag is set.
  - 0x08 CYCLES. A 32-bit counter that increments every cycle and wraps from 0xFFFFFFFF to 0. Reads return the current value. A write loads WriteData at the edge instead of incrementing, so the next cycle reads WriteData and the cycle after reads WriteData+1.
- FIFO:
  - Circular buffer with read/write pointers and an occupancy count.
  - out_valid = !empty; out_data = head entry, held stable while out_valid=1 and out_ready=0.
  - Pop happens at the edge when out_valid and out_ready are both 1.
  - Push and pop in the same cycle:
    - When full, both succeed, count is unchanged and overflow does not set.
    - When empty, the push succeeds and out_valid rises the next cycle (no same-cycle bypass).
  - out_ready while empty has no effect.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset (reset=0, asynchronous):
  - FIFO empty, pointers 0, overflow 0, CYCLES 0, out_valid 0.
  - ReadData for STATUS reads shows 32'h1.
  - All writes are ignored while reset=0.
  - Reset asserted mid-operation discards FIFO contents immediately and does not alter RAM.
- Latency: loads 0 cycles (combinational); stores and MMIO side effects visible 1 cycle after the edge.

Test Plan:
1. RAM store/load and alias: write 0xDEADBEEF to 0x00000010, then read 0x00000010 and 0x00000110 (DEPTH_WORDS=64) -> both return 0xDEADBEEF; a same-cycle read during the write returns the prior value.
2. FIFO fill/overflow: out_ready=0, write 0x41,0x42,0x43,0x44,0x45 to 0xFFFF0000 -> STATUS=0x22 after four writes (full, count 4), then 0x26 after the fifth (overflow set); writing 0x4 to STATUS -> 0x22.
3. Drain handshake: from the full state, hold out_ready=1 -> out_data sequence 0x41,0x42,0x43,0x44 on consecutive cycles; out_valid=0 after the fourth pop; STATUS=0x01.
4. Simultaneous push/pop when full: full FIFO, out_ready=1 and write 0x55 in the same cycle -> 0x41 popped, count stays 4, overflow stays 0, 0x55 appears last in the drain order.
5. Counter: write 0xFFFFFFFE to 0xFFFF0008 -> reads 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000 on the next three cycles.
6. Async reset mid-drain: FIFO holding 3 bytes, drop reset between clock edges -> out_valid=0 immediately, STATUS=0x01, CYCLES=0; RAM word at 0x10 is still 0xDEADBEEF after release.
